hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_div_tracker.sv | 70 +++++++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared divider state type, register-zero constant and latency default
package hazard_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_WB   = 2'd2
   } div_state_e;

   localparam logic [4:0] REG_ZERO            = 5'd0;
   localparam int         DIV_LATENCY_DEFAULT = 8;

   // A source only conflicts with a producer if it is really read and the producer is not $0.
   function automatic logic reg_hit(input logic use_src, input logic [4:0] src,
                                    input logic [4:0] dst);
      return use_src && (src == dst) && (dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard response bundle
interface hazard_scoreboard_if;

   logic       ID_valid;
   logic [4:0] ID_Rs;
   logic [4:0] ID_Rt;
   logic       ID_use_rs;
   logic       ID_use_rt;
   logic       ID_regwrite;
   logic [4:0] ID_writereg;
   logic       ID_memread;
   logic       ID_isdiv;
   logic       flush;
   logic       stall;
   logic       div_busy;
   logic [4:0] div_writereg;
   logic       div_wb;

   modport master (
      output ID_valid, ID_Rs, ID_Rt, ID_use_rs, ID_use_rt, ID_regwrite,
             ID_writereg, ID_memread, ID_isdiv, flush,
      input  stall, div_busy, div_writereg, div_wb
   );

   modport slave (
      input  ID_valid, ID_Rs, ID_Rt, ID_use_rs, ID_use_rt, ID_regwrite,
             ID_writereg, ID_memread, ID_isdiv, flush,
      output stall, div_busy, div_writereg, div_wb
   );

endinterface

// File: rtl/hazard_div_tracker.sv
// rtl/hazard_div_tracker.sv - multi-cycle divider occupancy FSM with latched destination
import hazard_pkg::*;

module hazard_div_tracker #(
   parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [4:0] writereg_i,
   output div_state_e state_o,
   output logic       busy_o,
   output logic       wb_o,
   output logic [4:0] writereg_o
);

   localparam logic [3:0] CNT_LOAD = 4'(DIV_LATENCY - 1);

   div_state_e state_q;
   logic [3:0] cnt_q;
   logic       busy_q;
   logic       wb_q;
   logic [4:0] writereg_q;

   // busy/wb are registered alongside the state so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= DIV_IDLE;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
         wb_q       <= 1'b0;
         writereg_q <= REG_ZERO;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start_i) begin
                  state_q    <= DIV_BUSY;
                  cnt_q      <= CNT_LOAD;
                  writereg_q <= writereg_i;
                  busy_q     <= 1'b1;
               end
            end
            DIV_BUSY: begin
               if (cnt_q == 4'd0) begin
                  state_q <= DIV_WB;
                  wb_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DIV_WB: begin
               state_q <= DIV_IDLE;
               wb_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= DIV_IDLE;
               wb_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign state_o    = state_q;
   assign busy_o     = busy_q;
   assign wb_o       = wb_q;
   assign writereg_o = writereg_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use and divider hazard detection for the ID stage
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
import hazard_pkg::*;

module hazard_scoreboard #(
   parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_scoreboard_if.slave  id_if
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]         stall_count
`endif
);

   div_state_e div_state;
   logic       div_busy;
   logic       div_wb;
   logic [4:0] div_wreg;

   logic       ld_pend_q, ld_pend_d;
   logic [4:0] ld_reg_q, ld_reg_d;

   logic       issue;
   logic       div_active;
   logic       load_use;
   logic       div_raw;
   logic       div_waw;
   logic       div_struct;
   logic       stall_w;

   assign div_active = (div_state != DIV_IDLE);

   assign load_use   = ld_pend_q &&
                       (reg_hit(id_if.ID_use_rs, id_if.ID_Rs, ld_reg_q) ||
                        reg_hit(id_if.ID_use_rt, id_if.ID_Rt, ld_reg_q));
   assign div_raw    = div_active &&
                       (reg_hit(id_if.ID_use_rs, id_if.ID_Rs, div_wreg) ||
                        reg_hit(id_if.ID_use_rt, id_if.ID_Rt, div_wreg));
   assign div_waw    = div_active && reg_hit(id_if.ID_regwrite, id_if.ID_writereg, div_wreg);
   assign div_struct = id_if.ID_isdiv && div_active;

   assign stall_w = id_if.ID_valid && (load_use || div_raw || div_waw || div_struct);
   assign issue   = id_if.ID_valid && !stall_w && !id_if.flush;

   // The load shadow lasts exactly one cycle: any cycle without an issuing load clears it.
   always_comb begin
      ld_pend_d = issue && id_if.ID_memread && id_if.ID_regwrite;
      ld_reg_d  = ld_pend_d ? id_if.ID_writereg : ld_reg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_pend_q <= 1'b0;
         ld_reg_q  <= REG_ZERO;
      end else begin
         ld_pend_q <= ld_pend_d;
         ld_reg_q  <= ld_reg_d;
      end
   end

   hazard_div_tracker #(
      .DIV_LATENCY (DIV_LATENCY)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (issue && id_if.ID_isdiv),
      .writereg_i (id_if.ID_writereg),
      .state_o    (div_state),
      .busy_o     (div_busy),
      .wb_o       (div_wb),
      .writereg_o (div_wreg)
   );

   assign id_if.stall        = stall_w;
   assign id_if.div_busy     = div_busy;
   assign id_if.div_writereg = div_wreg;
   assign id_if.div_wb       = div_wb;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= 32'd0;
      end else if (stall_w && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard (HAZARD_STATS_EN aware)
module tb_hazard_scoreboard;

   typedef struct {
      logic       rst_n;
      logic       stall;
      logic       busy;
      logic       wb;
      logic [4:0] dwr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t exp_q[$];

   hazard_scoreboard_if bus ();

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count;
   int          stat_model = 0;
`endif

   hazard_scoreboard #(.DIV_LATENCY(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .id_if (bus)
`ifdef HAZARD_STATS_EN
      ,
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, got, exp);
      end
   endtask

   // Apply one cycle of ID inputs just after the edge and queue what the outputs must be.
   task automatic step(input logic rn, input logic v,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic rw, input logic [4:0] wr,
                       input logic mr, input logic dv, input logic fl,
                       input logic es, input logic eb, input logic ew,
                       input logic [4:0] ed);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n             = rn;
      bus.ID_valid      = v;
      bus.ID_Rs         = rs;
      bus.ID_use_rs     = urs;
      bus.ID_Rt         = rt;
      bus.ID_use_rt     = urt;
      bus.ID_regwrite   = rw;
      bus.ID_writereg   = wr;
      bus.ID_memread    = mr;
      bus.ID_isdiv      = dv;
      bus.flush         = fl;
      e.rst_n = rn;
      e.stall = es;
      e.busy  = eb;
      e.wb    = ew;
      e.dwr   = ed;
      exp_q.push_back(e);
   endtask

   task automatic ins(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic rw, input logic [4:0] wr,
                      input logic mr, input logic dv, input logic fl,
                      input logic es, input logic eb, input logic ew, input logic [4:0] ed);
      step(1'b1, 1'b1, rs, urs, rt, urt, rw, wr, mr, dv, fl, es, eb, ew, ed);
   endtask

   task automatic nop(input logic eb, input logic ew, input logic [4:0] ed);
      step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
           1'b0, eb, ew, ed);
   endtask

   // Monitor: compare the DUT against the queued expectation on the falling edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cyc++;
            chk("stall", int'(bus.stall), int'(e.stall));
            chk("div_busy", int'(bus.div_busy), int'(e.busy));
            chk("div_wb", int'(bus.div_wb), int'(e.wb));
            chk("div_writereg", int'(bus.div_writereg), int'(e.dwr));
`ifdef HAZARD_STATS_EN
            if (!e.rst_n) stat_model = 0;
            chk("stall_count", int'(stall_count), stat_model);
            if (e.rst_n && e.stall) stat_model++;
`endif
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog timeout cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst_n = 1'b0;
      bus.ID_valid = 1'b0; bus.ID_Rs = 5'd0; bus.ID_use_rs = 1'b0;
      bus.ID_Rt = 5'd0; bus.ID_use_rt = 1'b0; bus.ID_regwrite = 1'b0;
      bus.ID_writereg = 5'd0; bus.ID_memread = 1'b0; bus.ID_isdiv = 1'b0;
      bus.flush = 1'b0;

      // reset state
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      nop(1'b0, 1'b0, 5'd0);

      // lw $5 then consumer via Rs: one stall cycle only
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      ins(5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      // lw $3 then consumer via Rt
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      ins(5'd1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      // lw $3 then Rt=3 not actually read
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd1, 1'b1, 5'd3, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      // lw $0 then consumer of $0
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      // flushed load never arms the tracker
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      // invalid ID slot gates the stall and lets the shadow expire
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step(1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      // flush and stall together: stall visible, nothing issues
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      ins(5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

      // div $7 then consumer of $7: 8 BUSY + 1 WB stall cycles
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int k = 1; k <= 8; k++)
         ins(5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, (k == 1), 1'b1, 1'b1, 1'b0, 5'd7);
      ins(5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7);
      ins(5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7);

      // second div waits for IDLE; independent add issues; WAW on $8 stalls
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7);
      for (int k = 1; k <= 9; k++)
         ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (k == 9), 5'd7);
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7);
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
      ins(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8);
      for (int k = 13; k <= 19; k++) nop(1'b1, (k == 19), 5'd8);
      nop(1'b0, 1'b0, 5'd8);

      // div $0 never causes RAW/WAW stalls
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
      ins(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      for (int k = 2; k <= 9; k++) nop(1'b1, (k == 9), 5'd0);
      nop(1'b0, 1'b0, 5'd0);

      // reset at cnt=3 abandons the divide and releases the consumer at once
      ins(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int k = 1; k <= 4; k++)
         ins(5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7);
      step(1'b0, 1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      ins(5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      for (int k = 0; k < 10; k++) nop(1'b0, 1'b0, 5'd0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
